// File: rtl/uart_frame_decoder.sv
// Purpose: parses SYNC, LEN, payload, CHK byte frames and reports good or rejected frames.
// Latency: frame_valid/frame_error pulse one clk after the final byte (or the timeout expiry).
// Backpressure: none; every io_data_valid byte is consumed in its cycle.
module uart_frame_decoder #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 8,
  parameter int         TIMEOUT_CYCLES = 104_200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_data_valid,
  input  logic [7:0]  io_data_packet,
  output logic        frame_valid,
  output logic [3:0]  frame_len,
  output logic [63:0] frame_data,
  output logic        frame_error,
  output logic [1:0]  error_code
);

  localparam int            CW        = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, GET_LEN, GET_PAYLOAD, GET_CHK} state_t;

  state_t        state_q, state_d;
  logic [3:0]    len_q, len_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    chk_q, chk_d;
  logic [63:0]   buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          frame_valid_q, frame_valid_d;
  logic          frame_error_q, frame_error_d;
  logic [3:0]    frame_len_q, frame_len_d;
  logic [63:0]   frame_data_q, frame_data_d;
  logic [1:0]    error_code_q, error_code_d;

  // Next-state: byte handling per state, otherwise inter-byte timeout tracking.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    idx_d         = idx_q;
    chk_d         = chk_q;
    buf_d         = buf_q;
    cnt_d         = cnt_q;
    frame_valid_d = 1'b0;
    frame_error_d = 1'b0;
    frame_len_d   = frame_len_q;
    frame_data_d  = frame_data_q;
    error_code_d  = error_code_q;

    if (io_data_valid) begin
      // An arriving byte always wins over a timeout expiring in the same cycle.
      cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (io_data_packet == SYNC_BYTE) state_d = GET_LEN;
        end
        GET_LEN: begin
          if (io_data_packet == 8'd0 || io_data_packet > MAX_LEN_B) begin
            frame_error_d = 1'b1;
            error_code_d  = 2'b01;
            state_d       = IDLE;
          end else begin
            len_d   = io_data_packet[3:0];
            chk_d   = io_data_packet;
            idx_d   = 4'd0;
            state_d = GET_PAYLOAD;
          end
        end
        GET_PAYLOAD: begin
          buf_d[{idx_q[2:0], 3'b000} +: 8] = io_data_packet;
          chk_d = chk_q ^ io_data_packet;
          idx_d = idx_q + 4'd1;
          if (idx_q == len_q - 4'd1) state_d = GET_CHK;
        end
        default: begin
          if (io_data_packet == chk_q) begin
            frame_valid_d = 1'b1;
            frame_len_d   = len_q;
            // Slots beyond LEN may hold bytes of an older, longer frame.
            frame_data_d  = '0;
            for (int i = 0; i < 8; i++) begin
              if (i < int'(len_q)) frame_data_d[i*8 +: 8] = buf_q[i*8 +: 8];
            end
          end else begin
            frame_error_d = 1'b1;
            error_code_d  = 2'b10;
          end
          state_d = IDLE;
        end
      endcase
    end else if (state_q != IDLE) begin
      if (cnt_q == TO_LAST) begin
        frame_error_d = 1'b1;
        error_code_d  = 2'b11;
        state_d       = IDLE;
        cnt_d         = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State and registered outputs; reset aborts any frame without a pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      len_q         <= '0;
      idx_q         <= '0;
      chk_q         <= '0;
      buf_q         <= '0;
      cnt_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      frame_len_q   <= '0;
      frame_data_q  <= '0;
      error_code_q  <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      chk_q         <= chk_d;
      buf_q         <= buf_d;
      cnt_q         <= cnt_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
      frame_len_q   <= frame_len_d;
      frame_data_q  <= frame_data_d;
      error_code_q  <= error_code_d;
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_error = frame_error_q;
  assign frame_len   = frame_len_q;
  assign frame_data  = frame_data_q;
  assign error_code  = error_code_q;

endmodule

// File: doc/uart_frame_decoder.md
UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-002 Parameter MAX_LEN, default 8: maximum payload bytes per frame; legal range 1..8.
REQ-003 Parameter TIMEOUT_CYCLES, default 104_200: inter-byte timeout in clk cycles, about 2 byte times at 9600 baud on 50 MHz.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port io_data_valid, input, 1: one-cycle pulse marking a received byte.
REQ-007 Port io_data_packet, input, 8: received byte; sampled only when io_data_valid=1.
REQ-008 Port frame_valid, output, 1: one-cycle pulse indicating a good frame.
REQ-009 Port frame_len, output, 4: payload length of the last good frame.
REQ-010 Port frame_data, output, 64: payload of the last good frame; byte i sits at [8i+7:8i].
REQ-011 Port frame_error, output, 1: one-cycle pulse indicating a rejected frame.
REQ-012 Port error_code, output, 2: cause of the last error: 01 bad length, 10 checksum mismatch, 11 timeout.

Function
REQ-013 Frame format SHALL be: SYNC_BYTE, LEN, LEN payload bytes, CHK; CHK = XOR of LEN and all payload bytes.
REQ-014 The FSM SHALL have exactly four states: IDLE, GET_LEN, GET_PAYLOAD, GET_CHK.
REQ-015 In IDLE, a byte equal to SYNC_BYTE SHALL move the FSM to GET_LEN; any other byte SHALL be discarded with no output.
REQ-016 In GET_LEN, LEN=0 or LEN>MAX_LEN SHALL pulse frame_error with error_code=01 and return the FSM to IDLE.
REQ-017 In GET_LEN, a legal LEN SHALL be stored, SHALL seed the running XOR, SHALL clear the byte index, and SHALL move the FSM to GET_PAYLOAD.
REQ-018 In GET_PAYLOAD, each byte SHALL be written to working-buffer slot [index] and XORed into the checksum, and the index SHALL increment.
REQ-019 After byte LEN-1 is accepted, the FSM SHALL move from GET_PAYLOAD to GET_CHK.
REQ-020 In GET_CHK, a byte equal to the running XOR SHALL cause, on the next cycle: frame_valid=1, frame_len=LEN, and frame_data = working buffer with unused upper bytes zero; the FSM SHALL then go to IDLE.
REQ-021 In GET_CHK, a mismatched byte SHALL pulse frame_error with error_code=10 and return the FSM to IDLE.
REQ-022 Output latency SHALL be exactly one clk cycle from the final byte's io_data_valid to frame_valid or frame_error; all outputs SHALL be registered.
REQ-023 frame_len and frame_data SHALL change only when frame_valid pulses; they SHALL hold across errors.
REQ-024 error_code SHALL update only when frame_error pulses and SHALL otherwise hold.
REQ-025 The timeout counter SHALL clear on every accepted byte and on entry to IDLE.
REQ-026 The timeout counter SHALL increment every cycle in non-IDLE states without io_data_valid.
REQ-027 When the timeout counter reaches TIMEOUT_CYCLES-1, the block SHALL pulse frame_error with error_code=11 and go to IDLE.
REQ-028 If a byte arrives in the same cycle the timeout would expire, the byte SHALL win: it is processed and no timeout is raised.
REQ-029 frame_valid and frame_error SHALL never assert in the same cycle.
REQ-030 A SYNC_BYTE value arriving inside a frame SHALL be treated as ordinary data; there is no resynchronisation mid-frame.
REQ-031 The counter width SHALL be $clog2(TIMEOUT_CYCLES)+1, and the counter SHALL not wrap.

Reset
REQ-032 While reset=1, the block SHALL force state=IDLE, clear all counters, the working buffer and the checksum, and drive frame_valid=0, frame_error=0, frame_len=0, frame_data=0, error_code=00.
REQ-033 Reset asserted mid-frame SHALL abort the frame silently with no error pulse, and the next byte after deassertion SHALL be parsed from IDLE.

Verification
REQ-034 Good frame: A5,03,11,22,33,03 -> one cycle after the last byte, frame_valid=1, frame_len=3, frame_data=64'h0000_0000_0033_2211.
REQ-035 Bad checksum: A5,02,AA,BB,00 -> frame_error=1, error_code=10; frame_data keeps its previous value.
REQ-036 Bad length: A5,09 -> frame_error=1, error_code=01; a following A5,01,7E,7F -> frame_valid=1, frame_data[7:0]=7E.
REQ-037 Timeout: A5,02,10 then idle for TIMEOUT_CYCLES cycles -> frame_error=1, error_code=11 exactly at expiry; a byte on the expiry cycle -> no error.
REQ-038 Noise and reset: 00,FF,5A in IDLE -> no outputs; reset asserted during the payload of A5,04,.. -> all outputs 0, no pulse, and the next good frame decodes correctly.
